// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer:
// FSM state encoding and the bit-counter width helper.
package serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Enough bits to count 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter bounded to 0..WIDTH-1 with synchronous clear, count enable
// and a terminal-count flag that is high while the count equals WIDTH-1.
module bit_counter
   import serializer_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_count,
   output logic          o_tc
);

   logic [CW-1:0] r_count;

   // Clear wins over enable so a reload on the final beat restarts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes one WIDTH-bit word per handshake and
// emits it one bit per accepted serial beat, MSB- or LSB-first.
module piso_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             s_data,
   output logic             s_valid,
   input  logic             s_ready,
   output logic             s_last,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. The producer holds its payload stable until that edge; ready
   // may depend combinationally on the partner's signals. in_ready is such a
   // path: it follows s_ready on the final bit so a new word can load on the
   // same edge the last bit leaves, giving gap-free back-to-back frames.

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    w_count;
   logic             w_tc;
   logic             w_out_bit;
   logic             w_beat;
   logic             w_accept;
   logic             w_cnt_clr;

   assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      s_valid     = 1'b0;
      s_data      = 1'b0;
      s_last      = 1'b0;
      busy        = 1'b0;
      w_beat      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            w_accept = in_valid;
            if (in_valid) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            s_valid  = 1'b1;
            busy     = 1'b1;
            s_data   = w_out_bit;
            s_last   = w_tc;
            w_beat   = s_ready;
            in_ready = w_tc && s_ready;
            w_accept = in_valid && w_tc && s_ready;
            if (w_beat && w_tc && !w_accept) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shifting on the final beat too leaves the register all-zero when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
      end else if (w_accept) begin
         r_shreg <= in_data;
      end else if (w_beat) begin
         if (MSB_FIRST) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         end else begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end
      end
   end

   assign w_cnt_clr = w_accept || (w_beat && w_tc);

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_beat),
      .o_count (w_count),
      .o_tc    (w_tc)
   );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table, async-reset sequence and
// random traffic checked against a bit-queue model, for both bit orders.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         s_ready;

   logic m_in_ready, m_s_data, m_s_valid, m_s_last, m_busy;
   logic l_in_ready, l_s_data, l_s_valid, l_s_last, l_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (m_in_ready),
      .s_data   (m_s_data),
      .s_valid  (m_s_valid),
      .s_ready  (s_ready),
      .s_last   (m_s_last),
      .busy     (m_busy)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (l_in_ready),
      .s_data   (l_s_data),
      .s_valid  (l_s_valid),
      .s_ready  (s_ready),
      .s_last   (l_s_last),
      .busy     (l_busy)
   );

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic         ir;
      logic         sv;
      logic         sd;
      logic         sl;
      logic         bz;
   } vec_t;

   vec_t tbl[$];

   // Reference model: the bits still owed to the serial side, in send order.
   logic exp_q_m[$];
   logic exp_q_l[$];

   task automatic add(input logic v, input logic [W-1:0] d, input logic r,
                      input logic ir, input logic sv, input logic sd,
                      input logic sl, input logic bz);
      vec_t e;
      e.v = v; e.d = d; e.r = r; e.ir = ir; e.sv = sv; e.sd = sd; e.sl = sl; e.bz = bz;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      s_ready  = r;
      #1;
   endtask

   task automatic chk_reset_values();
      chk("rst_msb_in_ready", m_in_ready, 1'b1);
      chk("rst_msb_s_valid",  m_s_valid,  1'b0);
      chk("rst_msb_s_data",   m_s_data,   1'b0);
      chk("rst_msb_s_last",   m_s_last,   1'b0);
      chk("rst_msb_busy",     m_busy,     1'b0);
      chk("rst_lsb_in_ready", l_in_ready, 1'b1);
      chk("rst_lsb_s_valid",  l_s_valid,  1'b0);
      chk("rst_lsb_s_data",   l_s_data,   1'b0);
      chk("rst_lsb_s_last",   l_s_last,   1'b0);
      chk("rst_lsb_busy",     l_busy,     1'b0);
   endtask

   task automatic model_check();
      int  nm = exp_q_m.size();
      int  nl = exp_q_l.size();
      chk("mdl_msb_s_valid",  m_s_valid,  nm > 0);
      chk("mdl_msb_s_data",   m_s_data,   (nm > 0) ? exp_q_m[0] : 1'b0);
      chk("mdl_msb_s_last",   m_s_last,   nm == 1);
      chk("mdl_msb_busy",     m_busy,     nm > 0);
      chk("mdl_msb_in_ready", m_in_ready, (nm == 0) || (nm == 1 && s_ready));
      chk("mdl_lsb_s_valid",  l_s_valid,  nl > 0);
      chk("mdl_lsb_s_data",   l_s_data,   (nl > 0) ? exp_q_l[0] : 1'b0);
      chk("mdl_lsb_s_last",   l_s_last,   nl == 1);
      chk("mdl_lsb_busy",     l_busy,     nl > 0);
      chk("mdl_lsb_in_ready", l_in_ready, (nl == 0) || (nl == 1 && s_ready));
   endtask

   // Advances the model across one rising edge; reports whether a word loaded.
   task automatic advance(output logic acc);
      logic         beat;
      logic [W-1:0] d;
      int           n;
      n    = exp_q_m.size();
      beat = (n > 0) && s_ready;
      acc  = in_valid && ((n == 0) || (n == 1 && s_ready));
      d    = in_data;
      @(posedge clk);
      if (beat) begin
         void'(exp_q_m.pop_front());
         void'(exp_q_l.pop_front());
      end
      if (acc) begin
         for (int b = W - 1; b >= 0; b--) exp_q_m.push_back(d[b]);
         for (int b = 0; b < W; b++)      exp_q_l.push_back(d[b]);
      end
   endtask

   initial begin
      logic         acc;
      logic         pend_v;
      logic [W-1:0] pend_d;
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic [W-1:0] pat;

      // v d r | in_ready s_valid s_data s_last busy  (MSB-first instance)
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0);   // idle after reset
      add(1, 4'b1011, 1, 1, 0, 0, 0, 0);   // accept 1011
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 0, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1, 1, 1);   // last bit
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0);   // busy fell
      add(1, 4'b1011, 1, 1, 0, 0, 0, 0);   // back-pressure frame
      add(0, 4'b0000, 0, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 0, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 0, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1, 1, 1);
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
      add(1, 4'b1011, 1, 1, 0, 0, 0, 0);   // back-to-back 1011, 0110
      add(1, 4'b0110, 1, 0, 1, 1, 0, 1);
      add(1, 4'b0110, 1, 0, 1, 0, 0, 1);
      add(1, 4'b0110, 1, 0, 1, 1, 0, 1);
      add(1, 4'b0110, 1, 1, 1, 1, 1, 1);   // reload on the last beat
      add(0, 4'b0000, 1, 0, 1, 0, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 0, 1, 1);
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
      add(1, 4'b1011, 1, 1, 0, 0, 0, 0);   // mid-frame word ignored
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(1, 4'b0000, 1, 0, 1, 0, 0, 1);
      add(0, 4'b0000, 1, 0, 1, 1, 0, 1);
      add(0, 4'b0000, 1, 1, 1, 1, 1, 1);
      add(0, 4'b0000, 1, 1, 0, 0, 0, 0);

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      s_ready  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_values();
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].r);
         chk("tbl_in_ready", m_in_ready, tbl[i].ir);
         chk("tbl_s_valid",  m_s_valid,  tbl[i].sv);
         chk("tbl_s_data",   m_s_data,   tbl[i].sd);
         chk("tbl_s_last",   m_s_last,   tbl[i].sl);
         chk("tbl_busy",     m_busy,     tbl[i].bz);
         model_check();
         advance(acc);
      end

      // Asynchronous reset two bits into a frame, then a clean frame.
      drive(1'b1, 4'b1011, 1'b1); model_check(); advance(acc);
      drive(1'b0, 4'b0000, 1'b1); model_check(); advance(acc);
      drive(1'b0, 4'b0000, 1'b1); model_check(); advance(acc);
      #2;
      chk("pre_rst_msb_s_valid", m_s_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_values();
      exp_q_m.delete();
      exp_q_l.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      pat = 4'b0001;
      drive(1'b1, pat, 1'b1); model_check(); advance(acc);
      for (int i = 0; i < W; i++) begin
         drive(1'b0, 4'b0000, 1'b1);
         chk("post_rst_msb_bit", m_s_data, pat[W-1-i]);
         chk("post_rst_lsb_bit", l_s_data, pat[i]);
         model_check();
         advance(acc);
      end

      pend_v = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 400; i++) begin
         if (pend_v) begin
            v = 1'b1;
            d = pend_d;
         end else begin
            v = ($urandom_range(0, 2) != 0);
            d = W'($urandom_range(0, (1 << W) - 1));
         end
         r = ($urandom_range(0, 3) != 0);
         drive(v, d, r);
         model_check();
         advance(acc);
         pend_v = v && !acc;
         pend_d = d;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
